// File: rtl/ysyx_23060240_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
// The ERR state is reachable only when MEM_ARB_TIMEOUT_EN is defined.
package ysyx_23060240_mem_pkg;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        ERR  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ysyx_23060240_mem_arbiter_if.sv
// Valid/ready request + response bundle shared by the IFU, LSU and memory sides.
interface ysyx_23060240_mem_arbiter_if
    import ysyx_23060240_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     addr;
    logic                  wen;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wmask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, addr, wen, wdata, wmask, rsp_ready,
        input  req_ready, rsp_valid, rdata, rsp_err
    );

    modport slave (
        input  req_valid, addr, wen, wdata, wmask, rsp_ready,
        output req_ready, rsp_valid, rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_23060240_mem_arbiter_rr_arb2.sv
// Two-way combinational round-robin grant: a lone requester always wins,
// on a tie the requester that was not granted last wins.
module ysyx_23060240_rr_arb2
    import ysyx_23060240_mem_pkg::*;
(
    input  logic req_0,
    input  logic req_1,
    input  logic last_owner,
    output logic gnt_0,
    output logic gnt_1
);

    // Grant selection
    always_comb begin
        gnt_0 = 1'b0;
        gnt_1 = 1'b0;
        if (req_0 && req_1) begin
            if (last_owner == OWNER_LSU) begin
                gnt_0 = 1'b1;
            end else begin
                gnt_1 = 1'b1;
            end
        end else if (req_0) begin
            gnt_0 = 1'b1;
        end else if (req_1) begin
            gnt_1 = 1'b1;
        end else begin
            gnt_0 = 1'b0;
            gnt_1 = 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_23060240_mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction at a time.
// Optional response watchdog with ERR state: define MEM_ARB_TIMEOUT_EN.
module ysyx_23060240_mem_arbiter
    import ysyx_23060240_mem_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                               clk,
    input  logic                               rst_n,
    ysyx_23060240_mem_arbiter_if.slave         ifu,
    ysyx_23060240_mem_arbiter_if.slave         lsu,
    ysyx_23060240_mem_arbiter_if.master        mem,
    output logic                               busy,
    output logic                               owner
);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic IDLE_RSP_READY = 1'b1;
`else
    localparam logic IDLE_RSP_READY = 1'b0;
`endif

    arb_state_e          state_r, state_nxt_s;
    logic                owner_r;
    logic                busy_r;
    logic                req_valid_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                wen_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W/8-1:0] wmask_r;

    logic idle_s, gnt_ifu_s, gnt_lsu_s, ifu_acc_s, lsu_acc_s;
    logic own_rsp_ready_s, wd_expired_s;

    ysyx_23060240_rr_arb2 u_rr_arb2 (
        .req_0      (ifu.req_valid),
        .req_1      (lsu.req_valid),
        .last_owner (owner_r),
        .gnt_0      (gnt_ifu_s),
        .gnt_1      (gnt_lsu_s)
    );

    // Ready is withheld while reset is asserted so nothing is accepted then.
    assign idle_s          = (state_r == IDLE) && rst_n;
    assign ifu.req_ready   = idle_s && gnt_ifu_s;
    assign lsu.req_ready   = idle_s && gnt_lsu_s;
    assign ifu_acc_s       = ifu.req_valid && ifu.req_ready;
    assign lsu_acc_s       = lsu.req_valid && lsu.req_ready;
    assign own_rsp_ready_s = (owner_r == OWNER_LSU) ? lsu.rsp_ready : ifu.rsp_ready;

    assign mem.req_valid = req_valid_r;
    assign mem.addr      = addr_r;
    assign mem.wen       = wen_r;
    assign mem.wdata     = wdata_r;
    assign mem.wmask     = wmask_r;
    assign busy          = busy_r;
    assign owner         = owner_r;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wd_cnt_r;

    // Watchdog: cleared while the request is being sent, counts silent WAIT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_r <= '0;
        end else if (state_r == SEND) begin
            wd_cnt_r <= '0;
        end else if ((state_r == WAIT) && !mem.rsp_valid) begin
            wd_cnt_r <= wd_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign wd_expired_s = (wd_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expired_s = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (ifu_acc_s || lsu_acc_s) state_nxt_s = SEND;
                else                        state_nxt_s = IDLE;
            end
            SEND: begin
                if (mem.req_ready) state_nxt_s = WAIT;
                else               state_nxt_s = SEND;
            end
            WAIT: begin
                if (mem.rsp_valid && own_rsp_ready_s) state_nxt_s = IDLE;
                else if (!mem.rsp_valid && wd_expired_s) state_nxt_s = ERR;
                else state_nxt_s = WAIT;
            end
            ERR: begin
                if (own_rsp_ready_s) state_nxt_s = IDLE;
                else                 state_nxt_s = ERR;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Response routing back to the current owner
    always_comb begin
        ifu.rsp_valid = 1'b0;
        ifu.rsp_err   = 1'b0;
        ifu.rdata     = {DATA_W{1'b0}};
        lsu.rsp_valid = 1'b0;
        lsu.rsp_err   = 1'b0;
        lsu.rdata     = {DATA_W{1'b0}};
        mem.rsp_ready = IDLE_RSP_READY;
        case (state_r)
            WAIT: begin
                mem.rsp_ready = own_rsp_ready_s;
                if (owner_r == OWNER_LSU) begin
                    lsu.rsp_valid = mem.rsp_valid;
                    lsu.rsp_err   = mem.rsp_err;
                    lsu.rdata     = mem.rdata;
                end else begin
                    ifu.rsp_valid = mem.rsp_valid;
                    ifu.rsp_err   = mem.rsp_err;
                    ifu.rdata     = mem.rdata;
                end
            end
`ifdef MEM_ARB_TIMEOUT_EN
            ERR: begin
                if (owner_r == OWNER_LSU) begin
                    lsu.rsp_valid = 1'b1;
                    lsu.rsp_err   = 1'b1;
                end else begin
                    ifu.rsp_valid = 1'b1;
                    ifu.rsp_err   = 1'b1;
                end
            end
`endif
            default: mem.rsp_ready = IDLE_RSP_READY;
        endcase
    end

    // State, owner and the registered downstream request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            owner_r     <= OWNER_IFU;
            busy_r      <= 1'b0;
            req_valid_r <= 1'b0;
            addr_r      <= '0;
            wen_r       <= 1'b0;
            wdata_r     <= '0;
            wmask_r     <= '0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s != IDLE);
            req_valid_r <= (state_nxt_s == SEND);
            if (lsu_acc_s) begin
                owner_r <= OWNER_LSU;
                addr_r  <= lsu.addr;
                wen_r   <= lsu.wen;
                wdata_r <= lsu.wdata;
                wmask_r <= lsu.wmask;
            end else if (ifu_acc_s) begin
                owner_r <= OWNER_IFU;
                addr_r  <= ifu.addr;
                wen_r   <= 1'b0;
                wdata_r <= ifu.wdata;
                wmask_r <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060240_mem_arbiter.sv
// Directed bench for ysyx_23060240_mem_arbiter: vector table plus hand sequences.
// The watchdog sequence is built only when MEM_ARB_TIMEOUT_EN is defined.
module tb_ysyx_23060240_mem_arbiter;
    import ysyx_23060240_mem_pkg::*;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int   TB_TIMEOUT     = 4;
    localparam logic IDLE_RSP_READY = 1'b1;
`else
    localparam int   TB_TIMEOUT     = 255;
    localparam logic IDLE_RSP_READY = 1'b0;
`endif

    typedef struct {
        logic        ifu_v;
        logic        lsu_v;
        logic [31:0] ifu_addr;
        logic [31:0] lsu_addr;
        logic        lsu_wen;
        logic [31:0] lsu_wdata;
        logic [3:0]  lsu_wmask;
        logic [31:0] rdata;
        logic        err;
        logic        exp_owner;
        logic [31:0] exp_addr;
        logic        exp_wen;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wmask;
    } vec_t;

    logic clk, rst_n, busy, owner;
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[6];

    ysyx_23060240_mem_arbiter_if ifu_bus ();
    ysyx_23060240_mem_arbiter_if lsu_bus ();
    ysyx_23060240_mem_arbiter_if mem_bus ();

    ysyx_23060240_mem_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifu   (ifu_bus),
        .lsu   (lsu_bus),
        .mem   (mem_bus),
        .busy  (busy),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench stalled");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        ifu_bus.req_valid = v.ifu_v;
        ifu_bus.addr      = v.ifu_addr;
        ifu_bus.wen       = 1'b1;
        ifu_bus.wdata     = 32'hFFFF_FFFF;
        ifu_bus.wmask     = 4'hF;
        lsu_bus.req_valid = v.lsu_v;
        lsu_bus.addr      = v.lsu_addr;
        lsu_bus.wen       = v.lsu_wen;
        lsu_bus.wdata     = v.lsu_wdata;
        lsu_bus.wmask     = v.lsu_wmask;
        ifu_bus.rsp_ready = 1'b1;
        lsu_bus.rsp_ready = 1'b1;
        mem_bus.req_ready = 1'b1;
        mem_bus.rsp_valid = 1'b0;
        #1;
        check("grant", {30'd0, ifu_bus.req_ready, lsu_bus.req_ready}, {30'd0, ~v.exp_owner, v.exp_owner});
        tick();
        ifu_bus.req_valid = 1'b0;
        lsu_bus.req_valid = 1'b0;
        #1;
        check("send_valid", {31'd0, mem_bus.req_valid}, 32'd1);
        check("owner", {31'd0, owner}, {31'd0, v.exp_owner});
        check("mem_addr", mem_bus.addr, v.exp_addr);
        check("mem_wen", {31'd0, mem_bus.wen}, {31'd0, v.exp_wen});
        check("mem_wmask", {28'd0, mem_bus.wmask}, {28'd0, v.exp_wmask});
        if (v.exp_wen) check("mem_wdata", mem_bus.wdata, v.exp_wdata);
        tick();
        mem_bus.rsp_valid = 1'b1;
        mem_bus.rdata     = v.rdata;
        mem_bus.rsp_err   = v.err;
        #1;
        check("req_dropped", {31'd0, mem_bus.req_valid}, 32'd0);
        check("own_rsp_valid", {31'd0, v.exp_owner ? lsu_bus.rsp_valid : ifu_bus.rsp_valid}, 32'd1);
        check("other_rsp_valid", {31'd0, v.exp_owner ? ifu_bus.rsp_valid : lsu_bus.rsp_valid}, 32'd0);
        check("rsp_rdata", v.exp_owner ? lsu_bus.rdata : ifu_bus.rdata, v.rdata);
        check("rsp_err", {31'd0, v.exp_owner ? lsu_bus.rsp_err : ifu_bus.rsp_err}, {31'd0, v.err});
        check("mem_rsp_ready", {31'd0, mem_bus.rsp_ready}, 32'd1);
        tick();
        mem_bus.rsp_valid = 1'b0;
        #1;
        check("idle_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic serve_one(output logic who, output logic ok);
        ok  = 1'b0;
        who = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            if (ifu_bus.req_ready || lsu_bus.req_ready) begin
                ok  = 1'b1;
                who = lsu_bus.req_ready;
            end else begin
                tick();
            end
        end
        if (ok) begin
            tick();
            tick();
            mem_bus.rsp_valid = 1'b1;
            #1;
            tick();
            mem_bus.rsp_valid = 1'b0;
            #1;
        end
    endtask

    initial begin
        logic who, ok;
        logic exp_rr[3];
        exp_rr = '{1'b1, 1'b0, 1'b1};

        vecs[0] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0000_0413, 1'b0,
                    1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h8000_0100, 1'b0, 32'h0, 4'hF, 32'h1122_3344, 1'b0,
                    1'b1, 32'h8000_0100, 1'b0, 32'h0, 4'hF};
        vecs[2] = '{1'b1, 1'b1, 32'h8000_0004, 32'h8000_0200, 1'b0, 32'h0, 4'hF, 32'h0010_0093, 1'b0,
                    1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0};
        vecs[3] = '{1'b1, 1'b1, 32'h8000_0008, 32'h8000_0300, 1'b1, 32'hCAFE_F00D, 4'hC, 32'h0, 1'b0,
                    1'b1, 32'h8000_0300, 1'b1, 32'hCAFE_F00D, 4'hC};
        vecs[4] = '{1'b0, 1'b1, 32'h0, 32'h8000_0400, 1'b0, 32'h0, 4'h1, 32'h0000_00A5, 1'b1,
                    1'b1, 32'h8000_0400, 1'b0, 32'h0, 4'h1};
        vecs[5] = '{1'b1, 1'b0, 32'h8000_000C, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0000_0013, 1'b1,
                    1'b0, 32'h8000_000C, 1'b0, 32'h0, 4'h0};

        // reset state, with both requesters already asking
        rst_n = 1'b1;
        ifu_bus.req_valid = 1'b1; ifu_bus.addr = 32'h0; ifu_bus.wen = 1'b0;
        ifu_bus.wdata = 32'h0; ifu_bus.wmask = 4'h0; ifu_bus.rsp_ready = 1'b0;
        lsu_bus.req_valid = 1'b1; lsu_bus.addr = 32'h0; lsu_bus.wen = 1'b0;
        lsu_bus.wdata = 32'h0; lsu_bus.wmask = 4'h0; lsu_bus.rsp_ready = 1'b0;
        mem_bus.req_ready = 1'b0; mem_bus.rsp_valid = 1'b0;
        mem_bus.rdata = 32'h0; mem_bus.rsp_err = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_owner", {31'd0, owner}, 32'd0);
        check("rst_mem_req_valid", {31'd0, mem_bus.req_valid}, 32'd0);
        check("rst_mem_addr", mem_bus.addr, 32'd0);
        check("rst_mem_wmask", {28'd0, mem_bus.wmask}, 32'd0);
        check("rst_mem_rsp_ready", {31'd0, mem_bus.rsp_ready}, {31'd0, IDLE_RSP_READY});
        check("rst_req_ready", {30'd0, ifu_bus.req_ready, lsu_bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {30'd0, ifu_bus.rsp_valid, lsu_bus.rsp_valid}, 32'd0);
        ifu_bus.req_valid = 1'b0;
        lsu_bus.req_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // store held off by mem_req_ready, then response back-pressure
        lsu_bus.req_valid = 1'b1; lsu_bus.addr = 32'h8000_1004; lsu_bus.wen = 1'b1;
        lsu_bus.wdata = 32'hDEAD_BEEF; lsu_bus.wmask = 4'b0011;
        mem_bus.req_ready = 1'b0;
        #1;
        tick();
        lsu_bus.req_valid = 1'b0; lsu_bus.addr = 32'h0; lsu_bus.wdata = 32'h0;
        lsu_bus.wmask = 4'h0; lsu_bus.wen = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("stall_valid", {31'd0, mem_bus.req_valid}, 32'd1);
            check("stall_addr", mem_bus.addr, 32'h8000_1004);
            check("stall_wdata", mem_bus.wdata, 32'hDEAD_BEEF);
            check("stall_wmask", {28'd0, mem_bus.wmask}, 32'h3);
            check("stall_wen", {31'd0, mem_bus.wen}, 32'd1);
            tick();
        end
        mem_bus.req_ready = 1'b1;
        #1;
        tick();
        check("single_handshake", {31'd0, mem_bus.req_valid}, 32'd0);
        mem_bus.rsp_valid = 1'b1; mem_bus.rdata = 32'h0; mem_bus.rsp_err = 1'b0;
        lsu_bus.rsp_ready = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            check("bp_lsu_rsp_valid", {31'd0, lsu_bus.rsp_valid}, 32'd1);
            check("bp_mem_rsp_ready", {31'd0, mem_bus.rsp_ready}, 32'd0);
            check("bp_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        lsu_bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, mem_bus.rsp_ready}, 32'd1);
        tick();
        mem_bus.rsp_valid = 1'b0;
        #1;
        check("bp_done", {31'd0, busy}, 32'd0);

        // asynchronous reset in the middle of WAIT
        lsu_bus.req_valid = 1'b1; lsu_bus.addr = 32'h8000_2000; lsu_bus.wmask = 4'hF;
        #1;
        tick();
        lsu_bus.req_valid = 1'b0;
        tick();
        mem_bus.rsp_valid = 1'b1; mem_bus.rdata = 32'h1234_5678;
        lsu_bus.rsp_ready = 1'b0;
        ifu_bus.req_valid = 1'b1;
        #1;
        check("pre_rst_rsp_valid", {31'd0, lsu_bus.rsp_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_owner", {31'd0, owner}, 32'd0);
        check("arst_mem_req_valid", {31'd0, mem_bus.req_valid}, 32'd0);
        check("arst_mem_rsp_ready", {31'd0, mem_bus.rsp_ready}, {31'd0, IDLE_RSP_READY});
        check("arst_rsp_valid", {30'd0, ifu_bus.rsp_valid, lsu_bus.rsp_valid}, 32'd0);
        check("arst_req_ready", {30'd0, ifu_bus.req_ready, lsu_bus.req_ready}, 32'd0);
        mem_bus.rsp_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        lsu_bus.rsp_ready = 1'b1; ifu_bus.rsp_ready = 1'b1;

        // both held after reset: LSU, IFU, LSU
        lsu_bus.req_valid = 1'b1;
        lsu_bus.wen = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            serve_one(who, ok);
            check("rr_progress", {31'd0, ok}, 32'd1);
            check("rr_grant", {31'd0, who}, {31'd0, exp_rr[k]});
        end
        ifu_bus.req_valid = 1'b0;
        lsu_bus.req_valid = 1'b0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // watchdog: no response ever arrives
        ifu_bus.req_valid = 1'b1; ifu_bus.addr = 32'h8000_0010; ifu_bus.rsp_ready = 1'b0;
        mem_bus.req_ready = 1'b1; mem_bus.rsp_valid = 1'b0; mem_bus.rdata = 32'hFFFF_FFFF;
        #1;
        tick();
        ifu_bus.req_valid = 1'b0;
        tick();
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (ifu_bus.rsp_valid) ok = 1'b1;
            else tick();
        end
        check("to_rsp_seen", {31'd0, ok}, 32'd1);
        check("to_rsp_err", {31'd0, ifu_bus.rsp_err}, 32'd1);
        check("to_rdata", ifu_bus.rdata, 32'd0);
        check("to_lsu_quiet", {31'd0, lsu_bus.rsp_valid}, 32'd0);
        tick();
        check("to_rsp_held", {31'd0, ifu_bus.rsp_valid}, 32'd1);
        ifu_bus.rsp_ready = 1'b1;
        #1;
        tick();
        check("to_idle", {31'd0, busy}, 32'd0);
        mem_bus.rsp_valid = 1'b1;
        #1;
        check("late_rsp_ready", {31'd0, mem_bus.rsp_ready}, 32'd1);
        check("late_rsp_dropped", {30'd0, ifu_bus.rsp_valid, lsu_bus.rsp_valid}, 32'd0);
        tick();
        check("late_still_idle", {31'd0, busy}, 32'd0);
        mem_bus.rsp_valid = 1'b0;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
